// File: rtl/pe_out_deskew_if.sv
// ============================================================================
//  pe_out_deskew_if
//  Row-output and aligned-word handshake bundle for pe_out_deskew.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface pe_out_deskew_if #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                 in_valid;
  logic [DATA_W-1:0]    pe_out1;
  logic [DATA_W-1:0]    pe_out2;
  logic [DATA_W-1:0]    pe_out3;
  logic [DATA_W-1:0]    pe_out4;
  logic [4*DATA_W-1:0]  o_data;
  logic                 o_valid;
  logic                 o_ready;
  logic [c_CNT_W-1:0]   fifo_cnt;
  logic                 overflow;

  // The array side plus the writeback consumer
  modport master (
    output in_valid, pe_out1, pe_out2, pe_out3, pe_out4, o_ready,
    input  o_data, o_valid, fifo_cnt, overflow
  );

  modport slave (
    input  in_valid, pe_out1, pe_out2, pe_out3, pe_out4, o_ready,
    output o_data, o_valid, fifo_cnt, overflow
  );
endinterface

`default_nettype wire

// File: rtl/pe_out_deskew.sv
// ============================================================================
//  pe_out_deskew
//  Re-aligns the four skewed PE row outputs into one word and buffers the
//  words in a small FIFO drained by valid/ready. Optional: PE_OUT_RELU_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pe_out_deskew #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  pe_out_deskew_if.slave    bus
);
  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam int c_WORD_W = 4 * DATA_W;

  // Row k lags row 1 by k-1 cycles, so earlier rows are held longer
  logic [DATA_W-1:0]   r_row1_d1, r_row1_d2, r_row1_d3;
  logic [DATA_W-1:0]   r_row2_d1, r_row2_d2;
  logic [DATA_W-1:0]   r_row3_d1;
  logic [2:0]          r_vld;

  logic [c_WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_overflow;

  logic [c_WORD_W-1:0] w_word_raw;
  logic [c_WORD_W-1:0] w_word;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row1_d1 <= '0;
      r_row1_d2 <= '0;
      r_row1_d3 <= '0;
      r_row2_d1 <= '0;
      r_row2_d2 <= '0;
      r_row3_d1 <= '0;
      r_vld     <= '0;
    end else begin
      r_row1_d1 <= bus.pe_out1;
      r_row1_d2 <= r_row1_d1;
      r_row1_d3 <= r_row1_d2;
      r_row2_d1 <= bus.pe_out2;
      r_row2_d2 <= r_row2_d1;
      r_row3_d1 <= bus.pe_out3;
      r_vld     <= {r_vld[1:0], bus.in_valid};
    end
  end

  assign w_word_raw = {bus.pe_out4, r_row3_d1, r_row2_d2, r_row1_d3};

`ifdef PE_OUT_RELU_EN
  // Any lane with the sign bit set, including -0, is clamped to +0
  for (genvar g = 0; g < 4; g++) begin : g_relu
    assign w_word[g*DATA_W +: DATA_W] =
        w_word_raw[(g+1)*DATA_W-1] ? '0 : w_word_raw[g*DATA_W +: DATA_W];
  end
`else
  assign w_word = w_word_raw;
`endif

  assign w_full = (r_count == c_CNT_W'(FIFO_DEPTH));
  assign w_pop  = (r_count != '0) && bus.o_ready;
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack
  assign w_push = r_vld[2] && (!w_full || w_pop);
  assign w_drop = r_vld[2] && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CNT_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.o_data   = r_mem[r_rd_ptr];
  assign bus.o_valid  = (r_count != '0);
  assign bus.fifo_cnt = r_count;
  assign bus.overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_pe_out_deskew.sv
// ============================================================================
//  tb_pe_out_deskew
//  Directed and randomized stimulus against a cycle-indexed reference model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pe_out_deskew;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int HIST   = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_out_deskew_if #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) bus ();

  pe_out_deskew #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: per-cycle record of inputs, plus a bounded word queue
  logic [15:0] h1 [HIST];
  logic [15:0] h2 [HIST];
  logic [15:0] h3 [HIST];
  logic [15:0] h4 [HIST];
  bit          hv [HIST];
  int          cyc      = 0;
  int          last_rst = -1;
  logic [63:0] q [$];
  bit          ovf_m    = 1'b0;

  function automatic logic [63:0] relu(input logic [63:0] w);
    logic [63:0] r;
    r = w;
`ifdef PE_OUT_RELU_EN
    for (int i = 0; i < 4; i++) begin
      if (r[16*i+15]) r[16*i +: 16] = 16'h0000;
    end
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    chk("o_valid", 64'(bus.o_valid), 64'(q.size() != 0));
    chk("fifo_cnt", 64'(bus.fifo_cnt), 64'(q.size()));
    chk("overflow", 64'(bus.overflow), 64'(ovf_m));
    if (q.size() != 0) chk("o_data", bus.o_data, q[0]);
  endtask

  // One word emerges for in_valid at cycle t when cycle t+3 ends,
  // unless a reset occurred in or after cycle t.
  task automatic model_edge(input bit rdy);
    bit          pop;
    bit          push;
    int          t;
    logic [63:0] w;
    pop  = (q.size() != 0) && rdy;
    t    = cyc - 3;
    push = (t >= 0) && hv[t] && (t > last_rst);
    w    = 64'h0;
    if (push) w = relu({h4[cyc], h3[cyc-1], h2[cyc-2], h1[t]});
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(w);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic tick(input bit iv, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] d, input bit rdy);
    bus.in_valid = iv;
    bus.pe_out1  = a;
    bus.pe_out2  = b;
    bus.pe_out3  = c;
    bus.pe_out4  = d;
    bus.o_ready  = rdy;
    h1[cyc] = a; h2[cyc] = b; h3[cyc] = c; h4[cyc] = d;
    hv[cyc] = iv;
    @(posedge clk);
    model_edge(rdy);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, rdy);
  endtask

  task automatic do_reset(input int n);
    bus.in_valid = 1'b0;
    bus.o_ready  = 1'b0;
    rst = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    for (int i = 0; i < n; i++) begin
      hv[cyc] = 1'b0;
      last_rst = cyc;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_outputs();
      chk("reset_o_data", bus.o_data, 64'h0);
    end
    rst = 1'b1;
  endtask

  function automatic logic [15:0] lane(input int k, input int i);
    int n;
    n = i - (k - 1);
    if (n >= 0 && n < 8) return {8'(k), 8'(n + 1)};
    return 16'h0;
  endfunction

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.pe_out1 = '0; bus.pe_out2 = '0; bus.pe_out3 = '0; bus.pe_out4 = '0;
    bus.o_ready = 1'b0;
    @(negedge clk);
    do_reset(2);

    // Single result, first visible four cycles after in_valid
    tick(1'b1, 16'h1111, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    tick(1'b0, 16'h0000, 16'h2222, 16'h0000, 16'h0000, 1'b0);
    tick(1'b0, 16'h0000, 16'h0000, 16'h3333, 16'h0000, 1'b0);
    chk("single_not_yet", 64'(bus.o_valid), 64'h0);
    tick(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h4444, 1'b0);
    chk("single_word", bus.o_data, 64'h4444_3333_2222_1111);
    chk("single_cnt", 64'(bus.fifo_cnt), 64'd1);
    idle(2, 1'b1);

    // Streaming eight back-to-back results with a ready consumer
    for (int i = 0; i < 12; i++) begin
      tick(i < 8, lane(1, i), lane(2, i), lane(3, i), lane(4, i), 1'b1);
      chk("stream_cnt_le1", 64'(bus.fifo_cnt <= CNT_W'(1)), 64'h1);
    end
    idle(2, 1'b1);

    // Fill and overflow: five results, consumer stalled
    for (int i = 0; i < 5; i++)
      tick(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    idle(4, 1'b0);
    chk("ovf_cnt_full", 64'(bus.fifo_cnt), 64'd4);
    chk("ovf_sticky", 64'(bus.overflow), 64'h1);
    idle(6, 1'b1);
    idle(3, 1'b0);
    chk("ovf_still_set", 64'(bus.overflow), 64'h1);
    do_reset(1);

    // Full FIFO with a push and pop landing on the same edge
    for (int i = 0; i < 4; i++)
      tick(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    idle(4, 1'b0);
    chk("full_before", 64'(bus.fifo_cnt), 64'd4);
    tick(1'b1, 16'hA001, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    tick(1'b0, 16'h0000, 16'hA002, 16'h0000, 16'h0000, 1'b0);
    tick(1'b0, 16'h0000, 16'h0000, 16'hA003, 16'h0000, 1'b0);
    tick(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hA004, 1'b1);
    chk("full_pop_cnt", 64'(bus.fifo_cnt), 64'd4);
    chk("full_pop_no_ovf", 64'(bus.overflow), 64'h0);
    idle(6, 1'b1);

    // Reset two cycles into a result's flight
    tick(1'b1, 16'h5151, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    tick(1'b0, 16'h0000, 16'h5252, 16'h0000, 16'h0000, 1'b0);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h5454, 1'b1);
      chk("midrst_no_word", 64'(bus.o_valid), 64'h0);
    end

    // Lane sign handling
    tick(1'b1, 16'hBC00, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    tick(1'b0, 16'h0000, 16'h3C00, 16'h0000, 16'h0000, 1'b0);
    tick(1'b0, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 1'b0);
    tick(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h7BFF, 1'b0);
`ifdef PE_OUT_RELU_EN
    chk("relu_word", bus.o_data, 64'h7BFF_0000_3C00_0000);
`else
    chk("relu_word", bus.o_data, 64'h7BFF_8000_3C00_BC00);
`endif
    idle(2, 1'b1);

    // Randomized traffic with a bursty consumer
    for (int i = 0; i < 120; i++)
      tick(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0) ^ (i >= 60 && i < 80));
    idle(8, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/pe_out_deskew.md
# pe_out_deskew

Output-side companion to the 4-row PE array. The array delays the weights by one extra cycle per row, so row k's partial sum appears k−1 cycles after row 1's. This block re-aligns the four 16-bit row outputs into one 64-bit word per array result and buffers those words in a small FIFO. It drains the FIFO through a valid/ready handshake toward the writeback/SRAM path.

## Interface
- DATA_W, 16, width of one row result (FP16 partial sum)
- FIFO_DEPTH, 4, aligned-word FIFO entries; power of 2, ≥2
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  marks the cycle in which pe_out1 carries a valid result
- pe_out1..pe_out4  input  DATA_W each  row 1..4 outputs of the PE array
- o_data  output  4*DATA_W  aligned word: [15:0]=row1, [31:16]=row2, [47:32]=row3, [63:48]=row4
- o_valid  output  1  FIFO head valid
- o_ready  input  1  consumer accepts head when o_valid && o_ready
- fifo_cnt  output  $clog2(FIFO_DEPTH)+1  current occupancy
- overflow  output  1  sticky flag: an aligned word was dropped

## Operation
- Deskew: pe_out1 delayed 3 cycles, pe_out2 2, pe_out3 1, pe_out4 0. in_valid goes through a matching 3-stage valid pipeline (v1→v2→v3).
- When v3 is high, the four aligned samples form one word and produce a push request. pe_out4 is sampled in the same cycle v3 is high.
- The FIFO is a circular buffer with wr_ptr/rd_ptr/count. Pointers wrap modulo FIFO_DEPTH.
- Pop on o_valid && o_ready. o_valid = (count != 0). o_data = mem[rd_ptr], combinational from registered storage.
- Push when not full: write and advance wr_ptr.
- Push while full:
  - With a pop in the same cycle: the push is accepted and count is unchanged.
  - Without a pop: the word is dropped, pointers and count are unchanged, and overflow is set to 1.
- overflow clears only on reset.
- Simultaneous push and pop when not full: both happen and count is unchanged.
- Pop while empty: impossible by construction, since o_valid=0.
- Back-to-back in_valid on every cycle is supported. Each in_valid pulse yields exactly one push request.

## Timing
- Reset values: o_valid=0, fifo_cnt=0, overflow=0, o_data=0. All delay registers, the valid pipeline, pointers and memory are cleared.
- in_valid high in cycle t: the word is written at the rising edge ending cycle t+3.
- If the FIFO was empty, o_valid=1 in cycle t+4. Minimum latency is 4 cycles.
- Throughput is one word per cycle in and out.
- fifo_cnt reflects the post-edge occupancy in the same cycle as o_valid.
- Reset asserted mid-operation: in-flight deskew samples and all FIFO contents are discarded immediately, with no partial word emitted after release.
- The first in_valid honoured after reset release is one sampled at a rising edge with rst=1.

## Configuration
- PE_OUT_RELU_EN defined: ReLU is applied per 16-bit lane at FIFO write. A lane with bit[15]=1 (negative FP16, including −0) is written as 16'h0000. Other lanes pass unchanged.
- PE_OUT_RELU_EN undefined: lanes are stored bit-exact. No ReLU logic is instantiated.

## Test plan
- Single result: in_valid at t. Drive pe_out1=16'h1111 at t, pe_out2=16'h2222 at t+1, pe_out3=16'h3333 at t+2, pe_out4=16'h4444 at t+3. Expect o_valid=1 at t+4 with o_data=64'h4444_3333_2222_1111; fifo_cnt=1.
- Streaming: in_valid for 8 consecutive cycles with o_ready=1, row k carrying value 16'h0k0n for result n. Expect 8 consecutive correctly aligned words, no overflow, and fifo_cnt ≤ 1.
- Full and overflow: o_ready=0, 5 results with FIFO_DEPTH=4. Expect fifo_cnt=4 and overflow=1 after the 5th push. Then o_ready=1: expect exactly results 1–4 to drain in order.
- Full with simultaneous pop: FIFO full, o_ready=1, and a push arrives in the same cycle. Expect the push accepted, fifo_cnt stays 4, and overflow stays 0.
- Reset mid-flight: in_valid at t, rst=0 during t+2, released at t+3. Expect o_valid=0 and fifo_cnt=0 through t+6, with no stale word emitted.
- ReLU (PE_OUT_RELU_EN defined): rows 16'hBC00, 16'h3C00, 16'h8000, 16'h7BFF. Expect o_data=64'h7BFF_0000_3C00_0000. Without the macro, expect 64'h7BFF_8000_3C00_BC00.
